// File: rtl/inert_spi_ctrl_if.sv
// Handshake between the inertial sequencer and the 16-bit SPI monarch:
// snd/cmd start a transaction, done/resp report its completion.
interface inert_spi_ctrl_if;
   logic        snd;
   logic [15:0] cmd;
   logic        done;
   logic [15:0] resp;

   modport master (output snd, output cmd, input done, input resp);
   modport slave  (input snd, input cmd, output done, output resp);
endinterface

// File: rtl/inert_spi_ctrl.sv
// Inertial sensor sequencer: power-up wait, config writes, then yaw-rate reads on INT.
// Optional INERT_AVG_EN averages every 4 yaw samples before raising vld.
module inert_spi_ctrl #(
   parameter int unsigned PWRUP_CYC = 65535
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             INT,
   inert_spi_ctrl_if.master spi,
   output logic             init_cmplt,
   output logic [15:0]      yaw_rt,
   output logic             vld
);

   localparam logic [15:0] PwrupLast = 16'(PWRUP_CYC - 1);
   localparam logic [15:0] CmdRdL    = 16'hA600;
   localparam logic [15:0] CmdRdH    = 16'hA700;

   typedef enum logic [2:0] {StPwrup, StCfg, StIdle, StRdL, StRdH} state_e;
   typedef enum logic [1:0] {PhIss, PhWait1, PhWait, PhGap} phase_e;

   state_e      state_q, state_d;
   phase_e      phase_q, phase_d;
   logic [15:0] pwr_cnt_q, pwr_cnt_d;
   logic [1:0]  cfg_idx_q, cfg_idx_d;
   logic        int_meta_q, int_s_q;
   logic        snd_q, snd_d;
   logic [15:0] cmd_q, cmd_d;
   logic        init_cmplt_q, init_cmplt_d;
   logic [7:0]  low_q, low_d;
   logic [15:0] yaw_q, yaw_d;
   logic        vld_q, vld_d;
   logic        xfer_done;
   logic [15:0] txn_cmd;
   logic [15:0] sample;
   logic        unused_resp;
`ifdef INERT_AVG_EN
   logic signed [17:0] acc_q, acc_d, acc_sum;
   logic [1:0]         smp_cnt_q, smp_cnt_d;
`endif

   function automatic logic [15:0] cfg_cmd(input logic [1:0] idx);
      case (idx)
         2'd0:    cfg_cmd = 16'h0D02;
         2'd1:    cfg_cmd = 16'h1053;
         2'd2:    cfg_cmd = 16'h1150;
         default: cfg_cmd = 16'h1460;
      endcase
   endfunction

   assign sample      = {spi.resp[7:0], low_q};
   assign unused_resp = ^spi.resp[15:8];
`ifdef INERT_AVG_EN
   assign acc_sum = acc_q + {{2{sample[15]}}, sample};
`endif

   always_comb begin
      case (state_q)
         StRdL:   txn_cmd = CmdRdL;
         StRdH:   txn_cmd = CmdRdH;
         default: txn_cmd = cfg_cmd(cfg_idx_q);
      endcase
   end

   always_comb begin
      state_d      = state_q;
      phase_d      = phase_q;
      pwr_cnt_d    = pwr_cnt_q;
      cfg_idx_d    = cfg_idx_q;
      snd_d        = 1'b0;
      cmd_d        = cmd_q;
      init_cmplt_d = init_cmplt_q;
      low_d        = low_q;
      yaw_d        = yaw_q;
      vld_d        = 1'b0;
      xfer_done    = 1'b0;
`ifdef INERT_AVG_EN
      acc_d        = acc_q;
      smp_cnt_d    = smp_cnt_q;
`endif

      case (state_q)
         StPwrup: begin
            pwr_cnt_d = pwr_cnt_q + 16'd1;
            if (pwr_cnt_q == PwrupLast) begin
               state_d   = StCfg;
               phase_d   = PhIss;
               cfg_idx_d = 2'd0;
               snd_d     = 1'b1;
               cmd_d     = cfg_cmd(2'd0);
            end
         end
         StIdle: begin
            if (int_s_q) begin
               state_d = StRdL;
               phase_d = PhIss;
               snd_d   = 1'b1;
               cmd_d   = CmdRdL;
            end
         end
         StCfg, StRdL, StRdH: begin
            case (phase_q)
               PhIss:   phase_d = PhWait1;
               // done can still be high from the previous frame here
               PhWait1: phase_d = PhWait;
               PhWait:  xfer_done = spi.done;
               PhGap: begin
                  snd_d   = 1'b1;
                  cmd_d   = txn_cmd;
                  phase_d = PhIss;
               end
            endcase
         end
         default: begin
            state_d   = StPwrup;
            pwr_cnt_d = '0;
         end
      endcase

      // Chained transactions pass through PhGap so done never abuts the next snd
      if (xfer_done) begin
         phase_d = PhGap;
         case (state_q)
            StCfg: begin
               if (cfg_idx_q == 2'd3) begin
                  init_cmplt_d = 1'b1;
                  state_d      = StIdle;
               end else begin
                  cfg_idx_d = cfg_idx_q + 2'd1;
               end
            end
            StRdL: begin
               low_d   = spi.resp[7:0];
               state_d = StRdH;
            end
            StRdH: begin
               state_d = StIdle;
`ifdef INERT_AVG_EN
               smp_cnt_d = smp_cnt_q + 2'd1;
               if (smp_cnt_q == 2'd3) begin
                  // acc_sum[17:2] is acc_sum >>> 2 truncated to 16 bits
                  yaw_d = acc_sum[17:2];
                  vld_d = 1'b1;
                  acc_d = '0;
               end else begin
                  acc_d = acc_sum;
               end
`else
               yaw_d = sample;
               vld_d = 1'b1;
`endif
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StPwrup;
         phase_q      <= PhIss;
         pwr_cnt_q    <= '0;
         cfg_idx_q    <= '0;
         int_meta_q   <= 1'b0;
         int_s_q      <= 1'b0;
         snd_q        <= 1'b0;
         cmd_q        <= '0;
         init_cmplt_q <= 1'b0;
         low_q        <= '0;
         yaw_q        <= '0;
         vld_q        <= 1'b0;
`ifdef INERT_AVG_EN
         acc_q        <= '0;
         smp_cnt_q    <= '0;
`endif
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         pwr_cnt_q    <= pwr_cnt_d;
         cfg_idx_q    <= cfg_idx_d;
         int_meta_q   <= INT;
         int_s_q      <= int_meta_q;
         snd_q        <= snd_d;
         cmd_q        <= cmd_d;
         init_cmplt_q <= init_cmplt_d;
         low_q        <= low_d;
         yaw_q        <= yaw_d;
         vld_q        <= vld_d;
`ifdef INERT_AVG_EN
         acc_q        <= acc_d;
         smp_cnt_q    <= smp_cnt_d;
`endif
      end
   end

   assign spi.snd    = snd_q;
   assign spi.cmd    = cmd_q;
   assign init_cmplt = init_cmplt_q;
   assign yaw_rt     = yaw_q;
   assign vld        = vld_q;

endmodule

// File: tb/tb_inert_spi_ctrl.sv
// Scoreboard bench for inert_spi_ctrl: SPI serf model, expected cmd/yaw queues.
// Honours INERT_AVG_EN in its yaw model.
module tb_inert_spi_ctrl;

   localparam int unsigned PwrupCyc = 16;
   localparam int          SerfLat  = 600;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        int_in = 1'b0;
   logic        init_cmplt;
   logic        vld;
   logic [15:0] yaw_rt;

   inert_spi_ctrl_if spi_if ();

   inert_spi_ctrl #(
      .PWRUP_CYC(PwrupCyc)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .INT       (int_in),
      .spi       (spi_if),
      .init_cmplt(init_cmplt),
      .yaw_rt    (yaw_rt),
      .vld       (vld)
   );

   always #10 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // SPI serf model
   bit          stale_mode = 1'b0;
   int          lat = 0;
   logic [15:0] cur_cmd = 16'h0;
   logic [7:0]  rd_lo = 8'h0;
   logic [7:0]  rd_hi = 8'h0;

   function automatic logic [15:0] resp_for(input logic [15:0] c);
      if (c == 16'hA600) return {8'h00, rd_lo};
      if (c == 16'hA700) return {8'hFF, rd_hi};
      return 16'h00E7;
   endfunction

   initial begin
      spi_if.done = 1'b0;
      spi_if.resp = 16'h0;
   end

   always @(posedge clk) begin
      if (spi_if.snd) begin
         cur_cmd <= spi_if.cmd;
         if (stale_mode) begin
            spi_if.done <= 1'b1;
            spi_if.resp <= resp_for(spi_if.cmd);
         end else begin
            spi_if.done <= 1'b0;
            lat         <= SerfLat;
         end
      end else if (stale_mode) begin
         spi_if.done <= 1'b1;
      end else if (lat != 0) begin
         lat <= lat - 1;
         if (lat == 1) begin
            spi_if.done <= 1'b1;
            spi_if.resp <= resp_for(cur_cmd);
         end
      end
   end

   // Scoreboard and monitor
   logic [31:0] exp_cmd[$];
   logic [31:0] exp_yaw[$];
   logic [31:0] mon_e;
   int  cyc = 0;
   int  last_snd_cyc = 0;
   int  since = 0;
   int  done_rises = 0;
   int  n_snd = 0;
   bit  snd_prev = 1'b0;
   bit  vld_prev = 1'b0;
   bit  done_prev = 1'b0;
   bit  outstanding = 1'b0;
   int  m_sum = 0;
   int  m_n = 0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (rst) begin
         snd_prev    = 1'b0;
         vld_prev    = 1'b0;
         outstanding = 1'b0;
      end else begin
         if (spi_if.snd) begin
            n_snd++;
            check("snd_width", 32'(snd_prev), 0);
            check("snd_before_done", 32'(outstanding), 0);
            if (exp_cmd.size() != 0) mon_e = exp_cmd.pop_front();
            else mon_e = 32'h1_0000;
            if (stale_mode && mon_e != 32'h0D02 && mon_e != 32'hA600)
               check("stale_wait_gap", 32'(cyc - last_snd_cyc), 4);
            check("cmd", {16'h0, spi_if.cmd}, mon_e);
            outstanding  = 1'b1;
            since        = 0;
            last_snd_cyc = cyc;
         end else begin
            since++;
            if (spi_if.done && since >= 1) outstanding = 1'b0;
         end
         if (vld) begin
            check("vld_width", 32'(vld_prev), 0);
            if (exp_yaw.size() != 0) mon_e = exp_yaw.pop_front();
            else mon_e = 32'h1_0000;
            check("yaw_rt", {16'h0, yaw_rt}, mon_e);
         end
         if (spi_if.done && !done_prev) done_rises++;
         snd_prev = spi_if.snd;
         vld_prev = vld;
      end
      done_prev = spi_if.done;
   end

   task automatic push_sample(input logic [15:0] s);
`ifdef INERT_AVG_EN
      int a;
      m_sum = m_sum + int'($signed(s));
      m_n++;
      if (m_n == 4) begin
         a = m_sum >>> 2;
         exp_yaw.push_back({16'h0, a[15:0]});
         m_sum = 0;
         m_n   = 0;
      end
`else
      exp_yaw.push_back({16'h0, s});
`endif
   endtask

   task automatic push_cfg();
      exp_cmd.push_back(32'h0D02);
      exp_cmd.push_back(32'h1053);
      exp_cmd.push_back(32'h1150);
      exp_cmd.push_back(32'h1460);
   endtask

   task automatic pulse_int();
      @(negedge clk) int_in = 1'b1;
      repeat (3) @(negedge clk);
      int_in = 1'b0;
   endtask

   task automatic wait_read_end(input string tag);
      int n;
      n = 0;
      while (exp_cmd.size() != 0 && n < 3000) begin @(negedge clk); n++; end
      if (!stale_mode) begin
         n = 0;
         while (spi_if.done && n < 10) begin @(negedge clk); n++; end
         n = 0;
         while (!spi_if.done && n < SerfLat + 20) begin @(negedge clk); n++; end
      end
      repeat (6) @(negedge clk);
      check(tag, 32'(exp_cmd.size() + exp_yaw.size()), 0);
   endtask

   task automatic do_read(input logic [15:0] s);
      rd_lo = s[7:0];
      rd_hi = s[15:8];
      exp_cmd.push_back(32'hA600);
      exp_cmd.push_back(32'hA700);
      push_sample(s);
      pulse_int();
      wait_read_end("read_drained");
   endtask

   task automatic pwrup_and_init(input string tag);
      int n;
      int base;
      base = n_snd;
      @(negedge clk) rst = 1'b0;
      push_cfg();
      n = 0;
      while (!spi_if.snd && n < 100) begin @(posedge clk); #1; n++; end
      check({tag, "_pwrup_lat"}, 32'(n), PwrupCyc);
      n = 0;
      while (!init_cmplt && n < 4 * (SerfLat + 20)) begin @(posedge clk); #1; n++; end
      check({tag, "_init_cmplt"}, 32'(init_cmplt), 1);
      check({tag, "_cfg_writes"}, 32'(n_snd - base), 4);
   endtask

   initial begin
      int n;
      int base;
      logic [15:0] samples[4];

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_snd", 32'(spi_if.snd), 0);
      check("rst_cmd", {16'h0, spi_if.cmd}, 0);
      check("rst_init_cmplt", 32'(init_cmplt), 0);
      check("rst_yaw_rt", {16'h0, yaw_rt}, 0);
      check("rst_vld", 32'(vld), 0);

      pwrup_and_init("boot");
      check("init_after_4th_done", 32'(done_rises), 4);

      samples = '{16'h1234, 16'h8000, 16'h7FFF, 16'hFFFF};
      foreach (samples[i]) do_read(samples[i]);

      // INT held high across a read, then a glitch during RD_H
      base  = n_snd;
      rd_lo = 8'h34;
      rd_hi = 8'h12;
      repeat (2) begin
         exp_cmd.push_back(32'hA600);
         exp_cmd.push_back(32'hA700);
         push_sample(16'h1234);
      end
      @(negedge clk) int_in = 1'b1;
      n = 0;
      while (exp_cmd.size() > 2 && n < 1500) begin @(negedge clk); n++; end
      n = 0;
      while (spi_if.done && n < 10) begin @(negedge clk); n++; end
      n = 0;
      while (!spi_if.done && n < SerfLat + 20) begin @(negedge clk); n++; end
      n = 0;
      while (exp_cmd.size() > 1 && n < 10) begin @(negedge clk); n++; end
      check("int_held_relaunch", 32'(n <= 3), 1);
      int_in = 1'b0;
      n = 0;
      while (exp_cmd.size() > 0 && n < 1500) begin @(negedge clk); n++; end
      repeat (5) @(negedge clk);
      pulse_int();
      wait_read_end("int_held_drained");
      repeat (40) @(negedge clk);
      check("int_glitch_no_extra", 32'(n_snd - base), 4);

      // Reset while waiting on the RD_L frame
      rd_lo = 8'h55;
      exp_cmd.push_back(32'hA600);
      pulse_int();
      n = 0;
      while (exp_cmd.size() > 0 && n < 100) begin @(negedge clk); n++; end
      repeat (10) @(negedge clk);
      rst        = 1'b1;
      stale_mode = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_init_cmplt", 32'(init_cmplt), 0);
      check("midrst_vld", 32'(vld), 0);
      check("midrst_snd", 32'(spi_if.snd), 0);
      exp_cmd.delete();
      exp_yaw.delete();
      m_sum = 0;
      m_n   = 0;
      pwrup_and_init("reinit");

      // Stale done held high: samples 100, 101, -3, -4
      samples = '{16'd100, 16'd101, 16'hFFFD, 16'hFFFC};
      foreach (samples[i]) do_read(samples[i]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: got time limit, expected completion");
      $fatal(1, "time limit");
   end

endmodule

// File: doc/inert_spi_ctrl.md
Name: inert_spi_ctrl

Overview:
- Transaction sequencer that sits directly upstream of the 16-bit SPI monarch and drives its snd/cmd, then consumes done/resp.
- After reset it waits a power-up interval and writes the inertial sensor configuration registers.
- It then reads the yaw-rate register pair each time the sensor raises INT, and presents the signed 16-bit yaw rate with a one-cycle valid pulse to the downstream heading logic.

Parameters:
- PWRUP_CYC, 65535: clocks to wait after reset before the first SPI write; legal range 1..65535.

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous reset, active-high
- INT  in  1  sensor data-ready interrupt; asynchronous, active-high
- snd  out  1  one-cycle pulse that starts an SPI transaction
- cmd  out  16  command word to the SPI monarch; held stable from the snd cycle until done
- done  in  1  SPI transaction complete; stays high until the next snd
- resp  in  16  SPI response; only [7:0] is used
- init_cmplt  out  1  high once all config writes have finished; sticky until rst
- yaw_rt  out  16  signed yaw rate, {high byte, low byte}
- vld  out  1  one-cycle pulse; yaw_rt is updated in the same cycle

Behaviour:
- Clock and reset: one clock domain, clk. Reset is synchronous, active-high, on rst.
- Reset values: snd=0, cmd=16'h0000, init_cmplt=0, yaw_rt=16'h0000, vld=0. State=PWRUP, power-up counter=0, INT synchronizer flops=0.
- INT synchronizer: INT passes through a 2-flop synchronizer; only the second flop output (INT_s) is used.
- PWRUP: the counter increments every clock. When it equals PWRUP_CYC-1, go to W_CFG with cfg index 0.
- Config table, written in index order:
  - 0: 16'h0D02 (INT on data ready)
  - 1: 16'h1053 (accel 208 Hz)
  - 2: 16'h1150 (gyro 208 Hz)
  - 3: 16'h1460 (rounding on)
- Each transaction uses sub-states ISSUE and WAIT:
  - ISSUE: drive cmd, pulse snd for exactly one cycle, go to WAIT.
  - WAIT: ignore done during the first WAIT cycle (done may still be high from the previous transaction). From the second WAIT cycle on, done=1 completes the transaction.
- W_CFG: on completion with index<3, increment the index and re-ISSUE. With index==3, set init_cmplt=1 and go to IDLE.
- IDLE: if INT_s=1, go to RD_L.
- RD_L: issue cmd=16'hA600. On completion, latch resp[7:0] into a low-byte register and go to RD_H.
- RD_H: issue cmd=16'hA700. On completion, yaw_rt <= {resp[7:0], low byte} and vld=1 in the following cycle, then return to IDLE.
- Minimum spacing: one snd per transaction; there is always at least one cycle between done and the next snd.
- INT handling: INT_s is level-checked only in IDLE. INT asserted during a read does not queue a second read. INT still high on return to IDLE starts a new read immediately.
- Reset mid-transaction: all state returns to PWRUP and the full init sequence repeats. The partial SPI frame is abandoned, and the SPI monarch completes on its own.
- Outside the snd cycle, cmd holds its last value.
- Unknown state encodings return to PWRUP.

Optional Feature:
- Macro INERT_AVG_EN.
- When defined:
  - The block accumulates 4 consecutive yaw samples in an 18-bit signed accumulator.
  - It asserts vld once per 4 reads with yaw_rt = accumulator>>>2 (arithmetic shift, truncation toward −∞), then clears the accumulator.
  - rst clears both the accumulator and the sample count.
- When undefined: every read produces vld, and no accumulator exists.

Test Plan:
- Reset and power-up: PWRUP_CYC=16, assert rst for 3 cycles → all outputs at reset values; first snd exactly 16 cycles after rst drops, with cmd=16'h0D02.
- Init sequence: SPI serf model, done 600 cycles after each snd → snd pulses carry cmd 0D02, 1053, 1150, 1460 in order; each snd is 1 cycle wide; init_cmplt rises after the 4th done; no snd before each prior done.
- Yaw read: serf returns resp 16'h0034 for A600 and 16'hFF12 for A700; pulse INT → snd with A600, then A700; yaw_rt=16'h1234 with vld high exactly 1 cycle.
- Stale done: hold done high continuously from the serf → the block does not advance on the first WAIT cycle after each snd.
- INT held high: read completes, INT still 1 → a new A600 snd is issued within 3 cycles of vld; an INT glitch during RD_H issues no extra read.
- Reset mid-read: assert rst during the RD_L wait → init_cmplt=0 and vld=0 next cycle; the sequence restarts from PWRUP and replays all 4 config writes.
- With INERT_AVG_EN: samples 100, 101, −3, −4 → single vld after the 4th read, yaw_rt=48 (194>>>2); no vld on reads 1–3.
